// File: rtl/data_mem_responder_pkg.sv
//------------------------------------------------------------------------------
// Module      : risc_v_mem_pkg
// Description : Shared types and constants for the data-memory responder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package risc_v_mem_pkg;

  // Longest programmable access latency, in cycles.
  localparam int LAT_MAX = 15;

  // Data word width of the memory port.
  localparam int WORD_W = 32;

  // Responder access sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Wait-counter preload for a latency: the first and last cycles are spent
  // in IDLE and on the edge into DONE, so only LAT-2 extra cycles are counted.
  function automatic logic [3:0] lat_preload(input int lat);
    return (lat >= 2) ? 4'(lat - 2) : 4'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_if.sv
//------------------------------------------------------------------------------
// Module      : data_mem_responder_if
// Description : Core <-> data-memory request/response bundle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface data_mem_responder_if;
  import risc_v_mem_pkg::*;

  logic [WORD_W-1:0] Address_data;
  logic [WORD_W-1:0] Data_write;
  logic              Wr_MEM_cntrl;
  logic              Rd_MEM_cntrl;
  logic [WORD_W-1:0] Data_from_memory;
  logic              Mem_ready;
  logic              Mem_err;

  // Core side: issues requests, receives completion.
  modport master (
    output Address_data,
    output Data_write,
    output Wr_MEM_cntrl,
    output Rd_MEM_cntrl,
    input  Data_from_memory,
    input  Mem_ready,
    input  Mem_err
  );

  // Memory side: accepts requests, signals completion.
  modport slave (
    input  Address_data,
    input  Data_write,
    input  Wr_MEM_cntrl,
    input  Rd_MEM_cntrl,
    output Data_from_memory,
    output Mem_ready,
    output Mem_err
  );

endinterface

`default_nettype wire

// File: rtl/data_mem_responder_storage.sv
//------------------------------------------------------------------------------
// Module      : dm_storage
// Description : Single-port word array, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dm_storage
  import risc_v_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  // Contents are deliberately left uninitialised and unaffected by reset.
  logic [WORD_W-1:0] mem_q [2**ADDR_W];

  // Commit a store on the clock edge when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : data_mem_responder
// Description : Data-memory responder with programmable read/write latency,
//               completion pulse and misaligned-access error pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_mem_responder
  import risc_v_mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic                 Clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam logic [3:0] RD_PRE = lat_preload(RD_LAT);
  localparam logic [3:0] WR_PRE = lat_preload(WR_LAT);

  // Out-of-range latencies would overflow the 4-bit wait counter.
  if ((RD_LAT < 1) || (RD_LAT > LAT_MAX) || (WR_LAT < 1) || (WR_LAT > LAT_MAX)) begin : g_lat_range_bad
    $error("data_mem_responder: RD_LAT and WR_LAT must be within 1..15");
  end

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              is_wr_q;
  logic [WORD_W-1:0] rdata_q;
  logic              ready_q;
  logic              err_q;

  logic              req;
  logic [WORD_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic              acc_wr;
  logic              lat_one;
  logic              fire;
  logic              misaligned;
  logic              store_we;
  logic [WORD_W-1:0] store_rdata;
  logic              unused_addr_hi;

  assign req = bus.Wr_MEM_cntrl | bus.Rd_MEM_cntrl;

  // Select the access operands: live inputs while a one-cycle access is being
  // sampled in IDLE, captured copies once the request is in flight.
  always_comb begin
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_wr    = is_wr_q;
    lat_one   = 1'b0;
    fire      = 1'b0;
    unique case (state_q)
      IDLE: begin
        acc_addr  = bus.Address_data;
        acc_wdata = bus.Data_write;
        acc_wr    = bus.Wr_MEM_cntrl;
        lat_one   = bus.Wr_MEM_cntrl ? (WR_LAT == 1) : (RD_LAT == 1);
        fire      = req & lat_one;
      end
      WAIT: begin
        fire = (cnt_q == 4'd0);
      end
      default: begin
      end
    endcase
  end

  assign misaligned     = |acc_addr[1:0];
  // Reset on the completing edge suppresses the store.
  assign store_we       = fire & acc_wr & ~misaligned & ~reset;
  assign unused_addr_hi = ^{acc_addr[WORD_W-1:ADDR_W+2]};

  dm_storage #(
    .ADDR_W (ADDR_W)
  ) u_storage (
    .clk_i   (Clk),
    .we_i    (store_we),
    .addr_i  (acc_addr[ADDR_W+1:2]),
    .wdata_i (acc_wdata),
    .rdata_o (store_rdata)
  );

  // Access sequencer: capture, count down the latency, complete with a pulse.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= bus.Address_data;
            wdata_q <= bus.Data_write;
            is_wr_q <= bus.Wr_MEM_cntrl;
            if (!lat_one) begin
              state_q <= WAIT;
              cnt_q   <= bus.Wr_MEM_cntrl ? WR_PRE : RD_PRE;
            end
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      // Completion overrides the per-state next state above.
      if (fire) begin
        state_q <= DONE;
        ready_q <= 1'b1;
        err_q   <= misaligned;
        if (!acc_wr) begin
          rdata_q <= misaligned ? '0 : store_rdata;
        end
      end
    end
  end

  assign bus.Data_from_memory = rdata_q;
  assign bus.Mem_ready        = ready_q;
  assign bus.Mem_err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_data_mem_responder
// Description : Scoreboard bench for two responder instances with different
//               latency settings.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   rdy_cnt_b = 0;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        e_a;
  exp_t        e_b;
  logic [31:0] mdl_a [int];
  logic [31:0] mdl_b [int];
  logic [31:0] last_a = 32'h0;
  logic [31:0] last_b = 32'h0;

  data_mem_responder_if ifa ();
  data_mem_responder_if ifb ();

  data_mem_responder #(.ADDR_W(10), .RD_LAT(2), .WR_LAT(1)) dut_a (
    .Clk   (clk),
    .reset (rst),
    .bus   (ifa)
  );

  data_mem_responder #(.ADDR_W(10), .RD_LAT(4), .WR_LAT(3)) dut_b (
    .Clk   (clk),
    .reset (rst),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every completion pops one expectation; a pulse with nothing
  // outstanding is reported as spurious.
  always @(negedge clk) begin
    if (ifa.Mem_ready === 1'b1) begin
      if (q_a.size() == 0) begin
        check_val("a_spurious_ready", {31'b0, ifa.Mem_ready}, 32'h0);
      end else begin
        e_a = q_a.pop_front();
        check_val("a_rdata", ifa.Data_from_memory, e_a.data);
        check_val("a_err", {31'b0, ifa.Mem_err}, {31'b0, e_a.err});
      end
    end else if (ifa.Mem_err === 1'b1) begin
      check_val("a_err_without_ready", {31'b0, ifa.Mem_err}, 32'h0);
    end
    if (ifb.Mem_ready === 1'b1) begin
      rdy_cnt_b = rdy_cnt_b + 1;
      if (q_b.size() == 0) begin
        check_val("b_spurious_ready", {31'b0, ifb.Mem_ready}, 32'h0);
      end else begin
        e_b = q_b.pop_front();
        check_val("b_rdata", ifb.Data_from_memory, e_b.data);
        check_val("b_err", {31'b0, ifb.Mem_err}, {31'b0, e_b.err});
      end
    end else if (ifb.Mem_err === 1'b1) begin
      check_val("b_err_without_ready", {31'b0, ifb.Mem_err}, 32'h0);
    end
  end

  task automatic drive(input int sel, input logic wr, input logic rd,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      ifa.Wr_MEM_cntrl = wr;
      ifa.Rd_MEM_cntrl = rd;
      ifa.Address_data = a;
      ifa.Data_write   = d;
    end else begin
      ifb.Wr_MEM_cntrl = wr;
      ifb.Rd_MEM_cntrl = rd;
      ifb.Address_data = a;
      ifb.Data_write   = d;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? ifa.Mem_ready : ifb.Mem_ready;
  endfunction

  // Issue one request, hold it until completion, check the latency.
  // Returns at the falling edge inside the completion cycle.
  task automatic access(input int sel, input logic wr, input logic rd,
                        input logic [31:0] addr, input logic [31:0] data,
                        input string tag, output int s_cyc);
    exp_t        e;
    int          word;
    int          lat_exp;
    int          lat;
    logic        mis;
    bit          got;
    logic [31:0] lat_obs;
    mis     = |addr[1:0];
    word    = int'(addr[11:2]);
    lat_exp = wr ? ((sel == 0) ? 1 : 3) : ((sel == 0) ? 2 : 4);
    e.err   = mis;
    e.data  = (sel == 0) ? last_a : last_b;
    if (wr) begin
      if (!mis) begin
        if (sel == 0) mdl_a[word] = data;
        else          mdl_b[word] = data;
      end
    end else begin
      if (mis)           e.data = 32'h0;
      else if (sel == 0) e.data = mdl_a.exists(word) ? mdl_a[word] : 32'hxxxx_xxxx;
      else               e.data = mdl_b.exists(word) ? mdl_b[word] : 32'hxxxx_xxxx;
      if (sel == 0) last_a = e.data;
      else          last_b = e.data;
    end
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
    @(posedge clk);
    #1;
    drive(sel, wr, rd, addr, data);
    s_cyc = cyc + 1;
    lat = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rdy(sel) === 1'b1) got = 1;
    end
    lat_obs = got ? 32'(lat) : 32'hFFFF_FFFF;
    check_val({tag, "_latency"}, lat_obs, 32'(lat_exp));
  endtask

  task automatic go_idle(input int sel);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int s0;
    int s1;
    int s2;
    int rc;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: outputs stay at their reset values.
    repeat (5) begin
      @(negedge clk);
      check_val("rst_a_ready", {31'b0, ifa.Mem_ready}, 32'h0);
      check_val("rst_a_err",   {31'b0, ifa.Mem_err},   32'h0);
      check_val("rst_a_data",  ifa.Data_from_memory,   32'h0);
      check_val("rst_b_ready", {31'b0, ifb.Mem_ready}, 32'h0);
      check_val("rst_b_data",  ifb.Data_from_memory,   32'h0);
    end

    // Write then read back on the short-latency instance.
    access(0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, "a_wr10", s0);
    access(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0,         "a_rd10", s0);
    go_idle(0);

    // Long read latency, request held across the access, back to back.
    access(1, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, "b_wr10", s0);
    access(1, 1'b0, 1'b1, 32'h0000_0010, 32'h0,         "b_rd10_1", s1);
    access(1, 1'b0, 1'b1, 32'h0000_0010, 32'h0,         "b_rd10_2", s2);
    check_val("b_access_spacing", 32'(s2 - s1), 32'd5);
    go_idle(1);

    // Misaligned write is refused; stored word unchanged.
    access(0, 1'b1, 1'b0, 32'h0000_0012, 32'hCAFE_F00D, "a_wr12_mis", s0);
    access(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0,         "a_rd10_after_mis", s0);
    // Misaligned read returns zero with an error.
    access(0, 1'b0, 1'b1, 32'h0000_0011, 32'h0,         "a_rd11_mis", s0);

    // Both strobes: treated as a write.
    access(0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, "a_both20", s0);
    access(0, 1'b0, 1'b1, 32'h0000_0020, 32'h0,         "a_rd20", s0);

    // Upper address bits alias onto the same word.
    access(0, 1'b1, 1'b0, 32'h8000_0024, 32'hA5A5_5A5A, "a_wr_alias", s0);
    access(0, 1'b0, 1'b1, 32'h0000_0024, 32'h0,         "a_rd_alias", s0);
    go_idle(0);

    // Reset lands on the edge that would complete a 3-cycle write.
    rc = rdy_cnt_b;
    @(posedge clk);
    #1;
    drive(1, 1'b1, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    last_a = 32'h0;
    last_b = 32'h0;
    repeat (3) @(negedge clk);
    check_val("b_no_ready_on_reset", 32'(rdy_cnt_b - rc), 32'd0);
    check_val("b_data_after_reset", ifb.Data_from_memory, 32'h0);
    check_val("a_data_after_reset", ifa.Data_from_memory, 32'h0);
    access(1, 1'b0, 1'b1, 32'h0000_0010, 32'h0, "b_rd10_after_reset", s0);
    go_idle(1);
    access(0, 1'b0, 1'b1, 32'h0000_0020, 32'h0, "a_rd20_after_reset", s0);
    go_idle(0);

    repeat (3) @(negedge clk);
    check_val("a_queue_drained", 32'(q_a.size()), 32'd0);
    check_val("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
